// File: rtl/sin_cos_scheduler.sv
// sin_cos_scheduler: round-robin front end that shares one first-quadrant sin_cos core.
// Angles are folded into quadrant 0 on the way in and results are unfolded by their tracked quadrant.
module sin_cos_scheduler #(
    parameter int NREQ    = 4,
    parameter int ASIZE   = 16,
    parameter int DSIZE   = 16,
    parameter int LATENCY = 16,
    parameter int IDW     = 2
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*ASIZE-1:0]          req_angle,
    output logic [NREQ-1:0]                req_ready,
    output logic [ASIZE-1:0]               core_angle,
    input  logic [DSIZE-1:0]               core_cos,
    input  logic [DSIZE-1:0]               core_sin,
    output logic                           rsp_valid,
    output logic [IDW-1:0]                 rsp_id,
    output logic [DSIZE:0]                 rsp_cos,
    output logic [DSIZE:0]                 rsp_sin,
    output logic [$clog2(LATENCY+3)-1:0]   inflight,
    output logic                           idle
);

    localparam int CW = $clog2(LATENCY+3);

    logic [IDW-1:0]    r_ptr;
    logic [ASIZE-1:0]  r_coreAngle;
    logic [LATENCY:0]  r_tagValid;
    logic [IDW-1:0]    r_tagId [0:LATENCY];
    logic [1:0]        r_tagQ  [0:LATENCY];
    logic              r_rspValid;
    logic [IDW-1:0]    r_rspId;
    logic [DSIZE:0]    r_rspCos;
    logic [DSIZE:0]    r_rspSin;
    logic [CW-1:0]     r_inflight;

    logic [NREQ-1:0]   w_grant;
    logic              w_found;
    logic [IDW-1:0]    w_grantId;
    logic [IDW-1:0]    w_nextPtr;
    logic [ASIZE-1:0]  w_angle;
    logic              w_accept;
    logic [DSIZE:0]    w_cosExt;
    logic [DSIZE:0]    w_sinExt;
    logic [DSIZE:0]    w_unCos;
    logic [DSIZE:0]    w_unSin;

    // Round-robin: first pass covers indices at/after the pointer, second pass wraps around.
    always_comb begin
        w_grant   = '0;
        w_found   = 1'b0;
        w_grantId = '0;
        w_nextPtr = r_ptr;
        w_angle   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_grantId  = IDW'(i);
                w_nextPtr  = (i == NREQ-1) ? '0 : IDW'(i+1);
                w_angle    = req_angle[i*ASIZE +: ASIZE];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (i < int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_grantId  = IDW'(i);
                w_nextPtr  = (i == NREQ-1) ? '0 : IDW'(i+1);
                w_angle    = req_angle[i*ASIZE +: ASIZE];
            end
        end
    end

    assign w_accept  = w_found & ~rst;
    assign req_ready = rst ? '0 : w_grant;

    assign w_cosExt = {1'b0, core_cos};
    assign w_sinExt = {1'b0, core_sin};

    always_comb begin
        w_unCos = w_cosExt;
        w_unSin = w_sinExt;
        case (r_tagQ[LATENCY])
            2'd0: begin w_unCos = w_cosExt;  w_unSin = w_sinExt;  end
            2'd1: begin w_unCos = -w_sinExt; w_unSin = w_cosExt;  end
            2'd2: begin w_unCos = -w_cosExt; w_unSin = -w_sinExt; end
            2'd3: begin w_unCos = w_sinExt;  w_unSin = -w_cosExt; end
            default: ;
        endcase
    end

    // Only the tag valids need reset; ids and quadrants are qualified by them.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_ptr       <= '0;
            r_coreAngle <= '0;
            r_tagValid  <= '0;
            r_rspValid  <= 1'b0;
            r_rspId     <= '0;
            r_rspCos    <= '0;
            r_rspSin    <= '0;
            r_inflight  <= '0;
        end else begin
            if (w_accept) begin
                r_ptr       <= w_nextPtr;
                r_coreAngle <= {w_angle[ASIZE-3:0], 2'b00};
            end
            r_tagValid <= {r_tagValid[LATENCY-1:0], w_accept};
            r_rspValid <= r_tagValid[LATENCY];
            if (r_tagValid[LATENCY]) begin
                r_rspId  <= r_tagId[LATENCY];
                r_rspCos <= w_unCos;
                r_rspSin <= w_unSin;
            end
            case ({w_accept, r_rspValid})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        r_tagId[0] <= w_grantId;
        r_tagQ[0]  <= w_angle[ASIZE-1:ASIZE-2];
        for (int k = 1; k <= LATENCY; k++) begin
            r_tagId[k] <= r_tagId[k-1];
            r_tagQ[k]  <= r_tagQ[k-1];
        end
    end

    assign core_angle = r_coreAngle;
    assign rsp_valid  = r_rspValid;
    assign rsp_id     = r_rspId;
    assign rsp_cos    = r_rspCos;
    assign rsp_sin    = r_rspSin;
    assign inflight   = r_inflight;
    assign idle       = (r_inflight == '0) && (req_valid == '0);

endmodule

// File: tb/tb_sin_cos_scheduler.sv
// Self-checking bench for sin_cos_scheduler using a delay-line core stub and a quadrant-rotation model.
// The stub either returns fixed cos/sin or values derived from the folded angle so ordering is visible.
module tb_sin_cos_scheduler;

    logic        clock;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_angle;
    logic [3:0]  req_ready;
    logic [15:0] core_angle;
    logic [15:0] core_cos;
    logic [15:0] core_sin;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [16:0] rsp_cos;
    logic [16:0] rsp_sin;
    logic [4:0]  inflight;
    logic        idle;

    sin_cos_scheduler #(.NREQ(4), .ASIZE(16), .DSIZE(16), .LATENCY(16), .IDW(2)) dut (
        .clock(clock), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .core_angle(core_angle), .core_cos(core_cos), .core_sin(core_sin),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .inflight(inflight), .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Core stub: pure delay line of the core angle, output mapped by stubMode.
    logic        stubMode = 1'b0;
    logic [15:0] pipe [0:15];
    initial for (int k = 0; k < 16; k++) pipe[k] = 16'h0;
    always @(posedge clock) begin
        pipe[0] <= core_angle;
        for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
    end
    assign core_cos = stubMode ? (pipe[15] ^ 16'hA5C3) : 16'h1234;
    assign core_sin = stubMode ? (pipe[15] + 16'h0101) : 16'h0567;

    int checks = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, actual, expected, cyc);
        end
    endtask

    // Expected response: stub value for the folded angle, rotated by the quadrant in 90-degree steps.
    function automatic void modelRsp(input int angle, input bit mode,
                                     output logic [31:0] ce, output logic [31:0] se);
        int q, fold, x, y, t;
        q    = angle / 16384;
        fold = (angle % 16384) * 4;
        if (mode) begin
            x = (fold ^ 32'hA5C3) & 32'hFFFF;
            y = (fold + 32'h0101) & 32'hFFFF;
        end else begin
            x = 32'h1234;
            y = 32'h0567;
        end
        repeat (q) begin
            t = x;
            x = -y;
            y = t;
        end
        ce = x & 32'h1FFFF;
        se = y & 32'h1FFFF;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] id;
        logic [31:0] cosv;
        logic [31:0] sinv;
    } exp_t;

    exp_t rq[$];
    int   mPtr = 0;
    int   mCore = 0;
    bit   checkEn = 1'b0;
    int   acceptCount [4];
    int   grantLog[$];
    int   rspSeen = 0;
    int   peak = 0;

    logic [3:0]  expReady;
    int          expId;
    int          accAngle;
    logic [31:0] ec, es;

    // Per-cycle comparison of every DUT output against the model, then model state update.
    always @(negedge clock) begin
        if (checkEn) begin
            expReady = 4'b0;
            expId = -1;
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    if (expId < 0 && req_valid[(mPtr + k) % 4]) expId = (mPtr + k) % 4;
                end
            end
            if (expId >= 0) expReady[expId] = 1'b1;
            checkOutput("req_ready", req_ready, expReady);
            checkOutput("core_angle", core_angle, mCore);
            checkOutput("inflight", inflight, rq.size());
            checkOutput("idle", idle, (rq.size() == 0 && req_valid == 4'b0));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                checkOutput("rsp_valid", rsp_valid, 1);
                checkOutput("rsp_id", rsp_id, rq[0].id);
                checkOutput("rsp_cos", rsp_cos, rq[0].cosv);
                checkOutput("rsp_sin", rsp_sin, rq[0].sinv);
                void'(rq.pop_front());
            end else begin
                checkOutput("rsp_valid_idle", rsp_valid, 0);
            end
            if (rsp_valid) rspSeen++;
            if (int'(inflight) > peak) peak = int'(inflight);
            if (rst) begin
                rq.delete();
                mPtr = 0;
                mCore = 0;
            end else if (expId >= 0) begin
                accAngle = int'((req_angle >> (expId * 16)) & 64'hFFFF);
                modelRsp(accAngle, stubMode, ec, es);
                rq.push_back('{cyc + 18, expId, ec, es});
                mPtr = (expId + 1) % 4;
                mCore = (accAngle % 16384) * 4;
                acceptCount[expId]++;
                grantLog.push_back(expId);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input logic [63:0] a);
        req_valid = v;
        req_angle = a;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        req_valid = 4'hF;
        @(posedge clock);
        #1;
        rst = 1'b0;
        req_valid = 4'h0;
    endtask

    task automatic waitRsp(output int at, output logic [31:0] id, output logic [31:0] c, output logic [31:0] s);
        at = -1;
        id = 0;
        c = 0;
        s = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock);
            #1;
            if (rsp_valid) begin
                at = cyc;
                id = rsp_id;
                c = rsp_cos;
                s = rsp_sin;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_timeout actual=none expected=rsp_valid within 40 cycles");
        end
    endtask

    int          tAcc, at, tLast, delay;
    logic [31:0] gId, gc, gs;
    logic [31:0] t2Cos [4];
    logic [31:0] t2Sin [4];

    initial begin
        t2Cos = '{32'h01234, 32'h1FA99, 32'h1EDCC, 32'h00567};
        t2Sin = '{32'h00567, 32'h01234, 32'h1FA99, 32'h1EDCC};
        rst = 1'b1;
        req_valid = 4'h0;
        req_angle = 64'h0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_req_ready", req_ready, 4'h0);
        req_valid = 4'h5;
        #1;
        checkOutput("reset_ready_gated", req_ready, 4'h0);
        req_valid = 4'h0;
        rst = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_cos", rsp_cos, 0);
        checkOutput("reset_inflight", inflight, 0);
        checkOutput("reset_core_angle", core_angle, 0);
        checkOutput("reset_idle", idle, 1);
        checkEn = 1'b1;

        // Single request in quadrant 1 with the fixed stub.
        tAcc = cyc;
        applyStimulus(4'b0001, 64'h4000);
        req_valid = 4'h0;
        checkOutput("t1_core_angle", core_angle, 16'h0000);
        waitRsp(at, gId, gc, gs);
        checkOutput("t1_latency", at - tAcc, 18);
        checkOutput("t1_id", gId, 0);
        checkOutput("t1_cos", gc, 32'h1FA99);
        checkOutput("t1_sin", gs, 32'h01234);
        repeat (3) applyStimulus(4'h0, 64'h0);

        // All four quadrants back-to-back.
        applyStimulus(4'b0001, 64'h0000);
        applyStimulus(4'b0001, 64'h4000);
        applyStimulus(4'b0001, 64'h8000);
        applyStimulus(4'b0001, 64'hC000);
        req_valid = 4'h0;
        waitRsp(at, gId, gc, gs);
        checkOutput("t2_cos0", gc, t2Cos[0]);
        checkOutput("t2_sin0", gs, t2Sin[0]);
        for (int k = 1; k < 4; k++) begin
            @(posedge clock);
            #1;
            checkOutput("t2_valid", rsp_valid, 1);
            checkOutput("t2_cos", rsp_cos, t2Cos[k]);
            checkOutput("t2_sin", rsp_sin, t2Sin[k]);
        end
        repeat (3) applyStimulus(4'h0, 64'h0);

        // Fairness with every requester valid, angle-dependent stub.
        doReset();
        stubMode = 1'b1;
        grantLog.delete();
        for (int k = 0; k < 4; k++) acceptCount[k] = 0;
        repeat (12) applyStimulus(4'hF, {$urandom(), $urandom()});
        req_valid = 4'h0;
        checkOutput("t3_grants", grantLog.size(), 12);
        for (int k = 0; k < 12 && k < grantLog.size(); k++) checkOutput("t3_order", grantLog[k], k % 4);
        for (int k = 0; k < 4; k++) checkOutput("t3_count", acceptCount[k], 3);
        repeat (25) applyStimulus(4'h0, 64'h0);

        // Reset while five results are in flight.
        rspSeen = 0;
        repeat (5) applyStimulus(4'b0100, {$urandom(), $urandom()});
        applyStimulus(4'h0, 64'h0);
        doReset();
        checkOutput("t4_inflight", inflight, 0);
        repeat (25) applyStimulus(4'h0, 64'h0);
        checkOutput("t4_no_rsp", rspSeen, 0);
        stubMode = 1'b0;
        tAcc = cyc;
        applyStimulus(4'b1000, {16'hC000, 48'h0});
        req_valid = 4'h0;
        waitRsp(at, gId, gc, gs);
        checkOutput("t4_latency", at - tAcc, 18);
        checkOutput("t4_id", gId, 3);
        checkOutput("t4_cos", gc, 32'h00567);
        checkOutput("t4_sin", gs, 32'h1EDCC);
        repeat (3) applyStimulus(4'h0, 64'h0);

        // Sparse traffic from requester 1 every third cycle.
        stubMode = 1'b1;
        peak = 0;
        applyStimulus(4'b0010, {32'h0, 16'h7123, 16'h0});
        checkOutput("t5_fold", core_angle, 16'hC48C);
        applyStimulus(4'h0, 64'h0);
        applyStimulus(4'h0, 64'h0);
        tLast = 0;
        for (int p = 1; p < 8; p++) begin
            tLast = cyc;
            applyStimulus(4'b0010, {32'h0, 16'($urandom()), 16'h0});
            applyStimulus(4'h0, 64'h0);
            applyStimulus(4'h0, 64'h0);
        end
        delay = -1;
        for (int n = 0; n < 30; n++) begin
            if (idle) begin
                delay = cyc - tLast;
                break;
            end
            @(posedge clock);
            #1;
        end
        checkOutput("t5_peak", peak, 6);
        checkOutput("t5_idle_delay", delay, 19);
        repeat (3) applyStimulus(4'h0, 64'h0);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
